img_rx_framer: RTL

- Parametrised successor to the UART image-transfer state tracker.
- Consumes the UART byte stream and detects a start marker.
- Assembles the following bytes into multi-byte pixels and writes them to frame memory with sequential addresses.
- Validates the frame length against a trailing end marker, aborts on an inter-byte timeout, and exports a state code plus done/error pulses to the display path.

---
 rtl/img_rx_framer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/img_rx_framer.sv
// UART image receiver: detects a start marker, packs bytes MSB-first into pixels,
// writes them to sequential frame addresses and checks the trailing end marker.
module img_rx_framer #(
    parameter int                 DATA_W       = 8,
    parameter logic [DATA_W-1:0]  START_BYTE   = 8'h5A,
    parameter logic [DATA_W-1:0]  END_BYTE     = 8'hA5,
    parameter int                 PIX_BYTES    = 2,
    parameter int                 FRAME_PIXELS = 20480,
    parameter int                 ADDR_W       = 15,
    parameter int                 TIMEOUT_CYC  = 15360
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        rx_valid,
    output logic [7:0]                  state,
    output logic                        pix_we,
    output logic [ADDR_W-1:0]           pix_addr,
    output logic [PIX_BYTES*DATA_W-1:0] pix_data,
    output logic                        frame_done,
    output logic                        frame_err
);

    localparam int PW    = PIX_BYTES * DATA_W;
    localparam int SH_W  = (PIX_BYTES > 1) ? (PIX_BYTES - 1) * DATA_W : DATA_W;
    localparam int BI_W  = $clog2(PIX_BYTES + 1);
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int TO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [BI_W-1:0]   BIDX_LAST = BI_W'(PIX_BYTES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_LAST_I);

    typedef enum logic [7:0] {
        S_IDLE = 8'h00,
        S_RECV = 8'h01,
        S_WAIT = 8'h02
    } state_t;

    state_t             r_state;
    logic               r_rx_prev;
    logic               r_pix_we;
    logic               r_done;
    logic               r_err;
    logic [ADDR_W-1:0]  r_pix_addr;
    logic [PW-1:0]      r_pix_data;
    logic [BI_W-1:0]    r_bidx;
    logic [TO_W-1:0]    r_to;
    logic [SH_W-1:0]    r_shift;

    state_t             w_state_nxt;
    logic               w_we_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [PW-1:0]      w_data_nxt;
    logic [BI_W-1:0]    w_bidx_nxt;
    logic [TO_W-1:0]    w_to_nxt;
    logic [SH_W-1:0]    w_shift_nxt;
    logic               w_stb;
    logic               w_to_hit;
    logic [PW-1:0]      w_word;

    assign w_stb    = rx_valid & ~r_rx_prev;
    assign w_to_hit = (TIMEOUT_CYC != 0) && (r_to == TO_LAST);

    // Pixel word as it will look once the current byte is appended (first byte ends up in the MSBs)
    generate
        if (PIX_BYTES == 1) begin : g_one
            assign w_word = data_in;
        end else begin : g_multi
            assign w_word = {r_shift, data_in};
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_addr_nxt  = r_pix_addr;
        w_data_nxt  = r_pix_data;
        w_bidx_nxt  = r_bidx;
        w_to_nxt    = r_to;
        w_shift_nxt = r_shift;

        // Pixel index advances the cycle after its write, and holds at the last pixel
        if (r_pix_we && (r_pix_addr != ADDR_LAST))
            w_addr_nxt = r_pix_addr + ADDR_W'(1);

        unique case (r_state)
            S_IDLE: begin
                if (w_stb && (data_in == START_BYTE)) begin
                    w_state_nxt = S_RECV;
                    w_addr_nxt  = '0;
                    w_bidx_nxt  = '0;
                    w_to_nxt    = '0;
                end
            end
            S_RECV: begin
                if (w_stb) begin
                    w_to_nxt    = '0;
                    w_shift_nxt = w_word[SH_W-1:0];
                    if (r_bidx == BIDX_LAST) begin
                        w_we_nxt   = 1'b1;
                        w_data_nxt = w_word;
                        w_bidx_nxt = '0;
                        if (r_pix_addr == ADDR_LAST)
                            w_state_nxt = S_WAIT;
                    end else begin
                        w_bidx_nxt = r_bidx + BI_W'(1);
                    end
                end else if (w_to_hit) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                    w_to_nxt    = '0;
                    w_bidx_nxt  = '0;
                end else if (TIMEOUT_CYC != 0) begin
                    w_to_nxt = r_to + TO_W'(1);
                end
            end
            S_WAIT: begin
                if (w_stb) begin
                    w_state_nxt = S_IDLE;
                    w_to_nxt    = '0;
                    if (data_in == END_BYTE)
                        w_done_nxt = 1'b1;
                    else
                        w_err_nxt = 1'b1;
                end else if (w_to_hit) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                    w_to_nxt    = '0;
                end else if (TIMEOUT_CYC != 0) begin
                    w_to_nxt = r_to + TO_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // rx_prev presets to 1 so a level already high at reset release is not a new byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rx_prev  <= 1'b1;
            r_pix_we   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_pix_addr <= '0;
            r_pix_data <= '0;
            r_bidx     <= '0;
            r_to       <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rx_prev  <= rx_valid;
            r_pix_we   <= w_we_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_pix_addr <= w_addr_nxt;
            r_pix_data <= w_data_nxt;
            r_bidx     <= w_bidx_nxt;
            r_to       <= w_to_nxt;
            r_shift    <= w_shift_nxt;
        end
    end

    assign state      = r_state;
    assign pix_we     = r_pix_we;
    assign pix_addr   = r_pix_addr;
    assign pix_data   = r_pix_data;
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule
